// File: rtl/bh_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bh_pkg
// Description : Shared opcode, error-code and width definitions for the
//               Brainfuck program loader.
// Revision    : 1.0
// ============================================================================
package bh_pkg;

    localparam int INSTR_W    = 3;
    localparam int PRG_AW_DEF = 8;
    localparam int STACK_AW   = 4;

    typedef logic [INSTR_W-1:0] opcode_t;

    localparam opcode_t OP_NOP   = 3'b000;
    localparam opcode_t OP_INC   = 3'b010;
    localparam opcode_t OP_DEC   = 3'b011;
    localparam opcode_t OP_RIGHT = 3'b100;
    localparam opcode_t OP_LEFT  = 3'b101;
    localparam opcode_t OP_OPEN  = 3'b110;
    localparam opcode_t OP_CLOSE = 3'b111;

    typedef logic [1:0] err_code_t;

    localparam err_code_t ERR_NONE      = 2'b00;
    localparam err_code_t ERR_OVERFLOW  = 2'b01;
    localparam err_code_t ERR_UNMATCHED = 2'b10;
    localparam err_code_t ERR_NESTING   = 2'b11;

    typedef struct packed {
        logic    is_cmd;
        opcode_t op;
    } decode_t;

endpackage
`default_nettype wire

// File: rtl/bh_char_decode.sv
`default_nettype none
// ============================================================================
// Module      : bh_char_decode
// Description : Maps an ASCII source byte to {is_cmd, opcode}.
// Revision    : 1.0
// ============================================================================
module bh_char_decode
    import bh_pkg::*;
(
    input  logic [7:0] ascii,
    output decode_t    dec
);

    always_comb begin
        dec = '{is_cmd: 1'b1, op: OP_NOP};
        case (ascii)
            8'h2B:   dec.op = OP_INC;
            8'h2D:   dec.op = OP_DEC;
            8'h3E:   dec.op = OP_RIGHT;
            8'h3C:   dec.op = OP_LEFT;
            8'h5B:   dec.op = OP_OPEN;
            8'h5D:   dec.op = OP_CLOSE;
            default: dec.is_cmd = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bh_loader.sv
`default_nettype none
// ============================================================================
// Module      : bh_loader
// Description : Filters a Brainfuck source stream into program memory, checks
//               bracket balance, pads with NOPs and gates the core's run enable.
// Revision    : 1.0
// ============================================================================
module bh_loader
    import bh_pkg::*;
#(
    parameter int PRG_AW    = PRG_AW_DEF,
    parameter int MAX_DEPTH = 15
) (
    input  logic              i_clock,
    input  logic              i_reset_n,
    input  logic              i_start,
    input  logic              i_src_valid,
    input  logic [7:0]        i_src_data,
    input  logic              i_src_last,
    output logic              o_src_ready,
    output logic              o_prgmem_in,
    output logic [PRG_AW-1:0] o_prgmem_addr,
    output logic [2:0]        o_prgmem_data,
    output logic              o_cpu_run,
    output logic              o_done,
    output logic              o_error,
    output logic [1:0]        o_error_code,
    output logic [PRG_AW:0]   o_length
);

    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FILL  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERROR = 3'd4;

    logic [2:0]         r_state, w_next;
    logic [PRG_AW:0]    r_count, w_count_next;
    logic [DEPTH_W-1:0] r_depth, w_depth_next;
    err_code_t          r_code, w_code_next;
    logic [PRG_AW-1:0]  r_fill;
    logic               r_src_ready;
    logic               r_wr_en;
    logic [PRG_AW-1:0]  r_wr_addr;
    opcode_t            r_wr_data;
    decode_t            w_dec;

    logic w_accept, w_cmd, w_full, w_err_ovf, w_err_close, w_err_open;
    logic w_write, w_restart;

    bh_char_decode u_dec (
        .ascii (i_src_data),
        .dec   (w_dec)
    );

    always_comb begin
        w_accept     = (r_state == S_LOAD) && i_src_valid && r_src_ready;
        w_cmd        = w_accept && w_dec.is_cmd;
        w_full       = r_count[PRG_AW];
        w_err_ovf    = w_cmd && w_full;
        w_err_close  = w_cmd && !w_full && (w_dec.op == OP_CLOSE) && (r_depth == '0);
        w_err_open   = w_cmd && !w_full && (w_dec.op == OP_OPEN)
                       && (r_depth == DEPTH_W'(MAX_DEPTH));
        w_write      = w_cmd && !w_err_ovf && !w_err_close && !w_err_open;
        w_count_next = r_count + {{PRG_AW{1'b0}}, w_write};
        w_depth_next = r_depth;
        if (w_write && (w_dec.op == OP_OPEN))
            w_depth_next = r_depth + 1'b1;
        else if (w_write && (w_dec.op == OP_CLOSE))
            w_depth_next = r_depth - 1'b1;
        w_restart    = i_start && ((r_state == S_IDLE) || (r_state == S_DONE)
                                   || (r_state == S_ERROR));
    end

    // State register; ready is registered from the next state so it drops
    // the cycle after an error or last-byte handshake.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_src_ready <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_src_ready <= (w_next == S_LOAD);
        end
    end

    always_comb begin
        w_next      = r_state;
        w_code_next = r_code;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_start) begin
                    w_next      = S_LOAD;
                    w_code_next = ERR_NONE;
                end
            end
            S_LOAD: begin
                if (w_err_ovf) begin
                    w_next      = S_ERROR;
                    w_code_next = ERR_OVERFLOW;
                end else if (w_err_close) begin
                    w_next      = S_ERROR;
                    w_code_next = ERR_UNMATCHED;
                end else if (w_err_open) begin
                    w_next      = S_ERROR;
                    w_code_next = ERR_NESTING;
                end else if (w_accept && i_src_last) begin
                    if (w_depth_next != '0) begin
                        w_next      = S_ERROR;
                        w_code_next = ERR_NESTING;
                    end else if (w_count_next[PRG_AW]) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (r_fill == '1)
                    w_next = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_count   <= '0;
            r_depth   <= '0;
            r_code    <= ERR_NONE;
            r_fill    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= OP_NOP;
        end else begin
            r_code <= w_code_next;
            if (w_restart) begin
                r_count <= '0;
                r_depth <= '0;
            end else begin
                r_count <= w_count_next;
                r_depth <= w_depth_next;
            end
            if (w_accept && i_src_last)
                r_fill <= w_count_next[PRG_AW-1:0];
            else if (r_state == S_FILL)
                r_fill <= r_fill + 1'b1;
            r_wr_en <= 1'b0;
            if (w_write) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_count[PRG_AW-1:0];
                r_wr_data <= w_dec.op;
            end else if (r_state == S_FILL) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_fill;
                r_wr_data <= OP_NOP;
            end
        end
    end

    // Completion is withheld while the final write is still on the bus.
    always_comb begin
        o_src_ready   = r_src_ready;
        o_prgmem_in   = r_wr_en;
        o_prgmem_addr = r_wr_addr;
        o_prgmem_data = r_wr_data;
        o_done        = (r_state == S_DONE) && !r_wr_en;
        o_cpu_run     = (r_state == S_DONE) && !r_wr_en;
        o_error       = (r_state == S_ERROR);
        o_error_code  = r_code;
        o_length      = r_count;
    end

endmodule
`default_nettype wire

// File: tb/tb_bh_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bh_loader
// Description : Scoreboard bench for bh_loader using directed source strings.
// Revision    : 1.0
// ============================================================================
module tb_bh_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       valid = 1'b0;
    logic       last = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready, wen, run, done, err;
    logic [7:0] waddr;
    logic [2:0] wdata;
    logic [1:0] code;
    logic [8:0] len;

    bh_loader dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_start       (start),
        .i_src_valid   (valid),
        .i_src_data    (data),
        .i_src_last    (last),
        .o_src_ready   (ready),
        .o_prgmem_in   (wen),
        .o_prgmem_addr (waddr),
        .o_prgmem_data (wdata),
        .o_cpu_run     (run),
        .o_done        (done),
        .o_error       (err),
        .o_error_code  (code),
        .o_length      (len)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [2:0] d;
    } wr_t;

    wr_t sb[$];
    int  total = 0;
    int  bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write on the memory port must match the oldest expectation.
    always @(negedge clk) begin
        if (wen === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0d data %0b expected none", waddr, wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", {24'd0, waddr}, {24'd0, e.a});
                chk("wr_data", {29'd0, wdata}, {29'd0, e.d});
            end
        end
    end

    task automatic push(input int a, input logic [2:0] d);
        wr_t e;
        e.a = a[7:0];
        e.d = d;
        sb.push_back(e);
    endtask

    task automatic push_fill(input int from);
        for (int a = from; a < 256; a++) push(a, 3'b000);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic l);
        int k = 0;
        valid = 1'b1;
        data  = b;
        last  = l;
        while (!ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (!ready) chk("ready_timeout", 0, 1);
        @(posedge clk); #1;
        valid = 1'b0;
        last  = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], i == s.len() - 1);
    endtask

    task automatic wait_end(input string name, input logic exp_done,
                            input logic [1:0] exp_code, input int exp_len);
        int k = 0;
        while (!(done || err) && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        chk({name, "_reached"}, {31'd0, done | err}, 1);
        if (exp_done) chk({name, "_done_after_write"}, {31'd0, wen}, 0);
        @(posedge clk); #1;
        chk({name, "_done"},  {31'd0, done}, {31'd0, exp_done});
        chk({name, "_run"},   {31'd0, run},  {31'd0, exp_done});
        chk({name, "_error"}, {31'd0, err},  {31'd0, ~exp_done});
        chk({name, "_code"},  {30'd0, code}, {30'd0, exp_code});
        chk({name, "_len"},   {23'd0, len},  exp_len);
        chk({name, "_ready"}, {31'd0, ready}, 0);
        chk({name, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, ready}, 0);
        chk("rst_wen",   {31'd0, wen}, 0);
        chk("rst_run",   {31'd0, run}, 0);
        chk("rst_done",  {31'd0, done}, 0);
        chk("rst_error", {31'd0, err}, 0);
        chk("rst_len",   {23'd0, len}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // "+[->+<]" followed by NOP padding
        pulse_start();
        chk("load_ready", {31'd0, ready}, 1);
        push(0, 3'b010); push(1, 3'b110); push(2, 3'b011); push(3, 3'b100);
        push(4, 3'b010); push(5, 3'b101); push(6, 3'b111); push_fill(7);
        send_str("+[->+<]");
        wait_end("loop", 1'b1, 2'b00, 7);

        // Non-command bytes are dropped
        pulse_start();
        push(0, 3'b010); push(1, 3'b100); push_fill(2);
        send_str("a+ .\n>");
        wait_end("filter", 1'b1, 2'b00, 2);

        // Unmatched ']'
        pulse_start();
        push(0, 3'b010);
        send("+", 1'b0);
        send("]", 1'b0);
        chk("unm_error_next", {31'd0, err}, 1);
        chk("unm_code_next", {30'd0, code}, 2);
        chk("unm_ready_next", {31'd0, ready}, 0);
        wait_end("unmatched", 1'b0, 2'b10, 1);

        // 16th nested '[' is too deep
        pulse_start();
        for (int i = 0; i < 15; i++) begin
            push(i, 3'b110);
            send("[", 1'b0);
        end
        send("[", 1'b0);
        wait_end("deep", 1'b0, 2'b11, 15);

        // Unclosed brackets at end of source
        pulse_start();
        push(0, 3'b110); push(1, 3'b110);
        send_str("[[");
        wait_end("unclosed", 1'b0, 2'b11, 2);
        repeat (5) @(posedge clk);
        #1;

        // 257 commands overflow
        pulse_start();
        for (int i = 0; i < 256; i++) begin
            push(i, 3'b010);
            send("+", 1'b0);
        end
        send("+", 1'b0);
        wait_end("overflow", 1'b0, 2'b01, 256);

        // Exactly 256 commands: DONE without fill
        pulse_start();
        for (int i = 0; i < 255; i++) begin
            push(i, 3'b011);
            send("-", 1'b0);
        end
        push(255, 3'b011);
        send("-", 1'b1);
        chk("full_last_write", {31'd0, wen}, 1);
        chk("full_done_early", {31'd0, done}, 0);
        @(posedge clk); #1;
        chk("full_done_n2", {31'd0, done}, 1);
        wait_end("full", 1'b1, 2'b00, 256);

        // Reset during fill, then a fresh load
        pulse_start();
        push(0, 3'b010); push_fill(1);
        send_str("+");
        k = 0;
        while (!(wen && waddr == 8'd100) && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        chk("fill_reached_100", {31'd0, wen}, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_wen",   {31'd0, wen}, 0);
        chk("mid_rst_addr",  {24'd0, waddr}, 0);
        chk("mid_rst_data",  {29'd0, wdata}, 0);
        chk("mid_rst_ready", {31'd0, ready}, 0);
        chk("mid_rst_run",   {31'd0, run}, 0);
        chk("mid_rst_done",  {31'd0, done}, 0);
        chk("mid_rst_error", {31'd0, err}, 0);
        chk("mid_rst_code",  {30'd0, code}, 0);
        chk("mid_rst_len",   {23'd0, len}, 0);
        sb.delete();
        rst_n = 1'b1;
        @(posedge clk); #1;
        pulse_start();
        push(0, 3'b011); push_fill(1);
        send_str("-");
        wait_end("after_rst", 1'b1, 2'b00, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
